// File: rtl/reg_write_arb_if.sv
// reg_write_arb_if -- bus bundle between the requesters and reg_write_arb.
//
// Optional feature macro: REG_WRITE_ARB_LOCK_EN adds the per-requester lock vector.
//
// Signals:
//   req       [NREQ]        per-requester write request (bit i = requester i)
//   in        [NREQ*WIDTH]  write data, requester i at [i*WIDTH +: WIDTH]
//   lock      [NREQ]        (REG_WRITE_ARB_LOCK_EN only) hold grant on the holder
//   gnt       [NREQ]        one-hot combinational grant
//   out       [WIDTH]       shared register value
//   out_valid               one-cycle pulse after each register write
//   src       [clog2(NREQ)] requester that performed the last write
//   wr_count  [8]           completed writes, wraps 255 -> 0
//
// Modports: master = requester side, slave = arbiter side.
interface reg_write_arb_if #(
  parameter int WIDTH = 2,
  parameter int NREQ  = 4
);
  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] in;
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      out;
  logic                  out_valid;
  logic [IW-1:0]         src;
  logic [7:0]            wr_count;
`ifdef REG_WRITE_ARB_LOCK_EN
  logic [NREQ-1:0]       lock;

  modport master (
    output req, in, lock,
    input  gnt, out, out_valid, src, wr_count
  );

  modport slave (
    input  req, in, lock,
    output gnt, out, out_valid, src, wr_count
  );
`else
  modport master (
    output req, in,
    input  gnt, out, out_valid, src, wr_count
  );

  modport slave (
    input  req, in,
    output gnt, out, out_valid, src, wr_count
  );
`endif
endinterface

// File: rtl/reg_write_arb.sv
// reg_write_arb -- round-robin arbiter granting write access to one shared
// WIDTH-bit register among NREQ requesters.
//
// Optional feature macro: REG_WRITE_ARB_LOCK_EN. When defined, the requester
// granted on the previous edge keeps the grant while it holds both req and
// lock; the round-robin pointer does not move while the lock is held.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  reg_write_arb_if.slave (req/in[/lock] in, gnt/out/out_valid/src/wr_count out)
//
// gnt is combinational and is the grant that is written on the coming edge;
// out/src/out_valid/wr_count update one cycle after the grant.
module reg_write_arb #(
  parameter int WIDTH = 2,
  parameter int NREQ  = 4
) (
  input  logic            clk,
  input  logic            rst,
  reg_write_arb_if.slave  bus
);

  localparam int IW = $clog2(NREQ);

  // Next index modulo NREQ, valid for non-power-of-two NREQ.
  function automatic logic [IW-1:0] idx_inc(input logic [IW-1:0] i);
    if (int'(i) == NREQ - 1) return '0;
    else                     return IW'(int'(i) + 1);
  endfunction

  logic [IW-1:0]    ptr;
  logic [WIDTH-1:0] out_p1;
  logic             vld_p1;
  logic [IW-1:0]    src_p1;
  logic [7:0]       cnt_p1;

  logic [NREQ-1:0]  gnt_p0;
  logic [IW-1:0]    gidx_p0;
  logic             vld_p0;
  logic             lock_hit;
  int               idx;

  // Stage p0: combinational grant selection
  always_comb begin
    gnt_p0   = '0;
    gidx_p0  = ptr;
    vld_p0   = 1'b0;
    lock_hit = 1'b0;
    idx      = 0;
`ifdef REG_WRITE_ARB_LOCK_EN
    // src_p1 is the holder only if a write actually happened on the last edge.
    lock_hit = vld_p1 && bus.req[src_p1] && bus.lock[src_p1];
`endif
    if (lock_hit) begin
      vld_p0  = 1'b1;
      gidx_p0 = src_p1;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        idx = int'(ptr) + k;
        if (idx >= NREQ) idx = idx - NREQ;
        if (!vld_p0 && bus.req[idx]) begin
          vld_p0  = 1'b1;
          gidx_p0 = IW'(idx);
        end
      end
    end
    if (rst) vld_p0 = 1'b0;
    if (vld_p0) gnt_p0[gidx_p0] = 1'b1;
  end

  // Stage p1: shared register write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_p1 <= '0;
      vld_p1 <= 1'b0;
      src_p1 <= '0;
      cnt_p1 <= '0;
      ptr    <= '0;
    end else if (vld_p0) begin
      out_p1 <= bus.in[int'(gidx_p0)*WIDTH +: WIDTH];
      vld_p1 <= 1'b1;
      src_p1 <= gidx_p0;
      cnt_p1 <= cnt_p1 + 8'd1;
      if (!lock_hit) ptr <= idx_inc(gidx_p0);
    end else begin
      vld_p1 <= 1'b0;
    end
  end

  assign bus.gnt       = gnt_p0;
  assign bus.out       = out_p1;
  assign bus.out_valid = vld_p1;
  assign bus.src       = src_p1;
  assign bus.wr_count  = cnt_p1;

endmodule

// File: tb/tb_reg_write_arb.sv
// tb_reg_write_arb -- directed bench for reg_write_arb (WIDTH=2, NREQ=4).
module tb_reg_write_arb;
  localparam int WIDTH = 2;
  localparam int NREQ  = 4;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  reg_write_arb_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

  reg_write_arb #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] exp_cnt;
    rst     = 1'b1;
    bus.req = 4'b1111;
    bus.in  = 8'hFF;
`ifdef REG_WRITE_ARB_LOCK_EN
    bus.lock = '0;
`endif
    // reset held with every requester asking
    for (int c = 0; c < 3; c++) begin
      step();
      chk("rst_gnt", 32'(bus.gnt), 0);
      chk("rst_out", 32'(bus.out), 0);
      chk("rst_cnt", 32'(bus.wr_count), 0);
      chk("rst_vld", 32'(bus.out_valid), 0);
    end
    rst     = 1'b0;
    bus.req = 4'b0000;
    #1 chk("idle_gnt", 32'(bus.gnt), 0);

    // single write from requester 2
    bus.req = 4'b0100;
    bus.in  = 8'h30;
    #1 chk("single_gnt", 32'(bus.gnt), 4'b0100);
    step();
    chk("single_out", 32'(bus.out), 3);
    chk("single_src", 32'(bus.src), 2);
    chk("single_vld", 32'(bus.out_valid), 1);
    chk("single_cnt", 32'(bus.wr_count), 1);
    bus.req = 4'b0000;
    #1 chk("single_gnt_off", 32'(bus.gnt), 0);
    step();
    chk("single_vld_off", 32'(bus.out_valid), 0);
    chk("single_out_hold", 32'(bus.out), 3);
    chk("single_cnt_hold", 32'(bus.wr_count), 1);

    // reset pulse, then all four requesting for 8 cycles
    rst = 1'b1;
    #1 chk("pulse_out", 32'(bus.out), 0);
    step();
    rst     = 1'b0;
    bus.in  = 8'hE4;
    bus.req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      #1 chk("rr_gnt", 32'(bus.gnt), 32'(1) << (i % 4));
      step();
      chk("rr_out", 32'(bus.out), i % 4);
    end
    chk("rr_cnt", 32'(bus.wr_count), 8);

    // ptr=1 with requesters 3 and 0 pending
    bus.req = 4'b0001;
    #1 chk("wrap_pre_gnt", 32'(bus.gnt), 4'b0001);
    step();
    bus.req = 4'b1001;
    #1 chk("wrap_gnt3", 32'(bus.gnt), 4'b1000);
    step();
    chk("wrap_src3", 32'(bus.src), 3);
    #1 chk("wrap_gnt0", 32'(bus.gnt), 4'b0001);
    step();
    chk("wrap_src0", 32'(bus.src), 0);
    chk("wrap_cnt", 32'(bus.wr_count), 11);

    // idle edge holds state
    bus.req = 4'b0000;
    step();
    chk("hold_vld", 32'(bus.out_valid), 0);
    chk("hold_src", 32'(bus.src), 0);
    chk("hold_out", 32'(bus.out), 0);
    chk("hold_cnt", 32'(bus.wr_count), 11);

    // asynchronous reset in mid-operation
    bus.req = 4'b1111;
    #1 chk("mid_gnt", 32'(bus.gnt), 4'b0010);
    rst = 1'b1;
    #1;
    chk("mid_rst_gnt", 32'(bus.gnt), 0);
    chk("mid_rst_cnt", 32'(bus.wr_count), 0);
    chk("mid_rst_out", 32'(bus.out), 0);
    step();
    chk("mid_rst_edge_cnt", 32'(bus.wr_count), 0);
    chk("mid_rst_edge_vld", 32'(bus.out_valid), 0);
    rst = 1'b0;
    #1 chk("resume_gnt", 32'(bus.gnt), 4'b0001);
    step();
    chk("resume_src", 32'(bus.src), 0);
    chk("resume_cnt", 32'(bus.wr_count), 1);

    // 256 single writes with idle cycles between
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int n = 1; n <= 256; n++) begin
      exp_cnt = 8'(n);
      bus.req = 4'b0001;
      bus.in  = 8'(n);
      step();
      chk("many_vld", 32'(bus.out_valid), 1);
      chk("many_out", 32'(bus.out), n % 4);
      chk("many_cnt", 32'(bus.wr_count), 32'(exp_cnt));
      bus.req = 4'b0000;
      step();
      chk("many_idle_vld", 32'(bus.out_valid), 0);
    end
    chk("many_wrap_cnt", 32'(bus.wr_count), 0);

`ifdef REG_WRITE_ARB_LOCK_EN
    // requester 1 holds the register with lock
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.req = 4'b0001;
    step();
    bus.req  = 4'b1111;
    bus.lock = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      #1 chk("lock_gnt", 32'(bus.gnt), 4'b0010);
      step();
      chk("lock_src", 32'(bus.src), 1);
    end
    bus.lock = 4'b0000;
    #1 chk("unlock_gnt", 32'(bus.gnt), 4'b0100);
    step();
    chk("unlock_src", 32'(bus.src), 2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
